// File: rtl/math_acc_dump.sv
// math_acc_dump: integrate-and-dump accumulator for signed samples.
// Sums len+1 valid samples, emits the sum with a one-cycle dout_valid pulse,
// then keeps integrating the next block without leaving RUN.
// Optional feature: define MATH_ACC_DUMP_SAT_EN to saturate on overflow
// (default build wraps modulo 2^ACC_WIDTH and only flags ovf).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   ena             clock enable for every register
//   start           begin / restart a run, latches len
//   len             samples per dump minus one
//   din_valid, din  signed input sample stream
//   busy            high while in RUN
//   dout_valid      one-cycle pulse with completed sum on dout
//   dout            last dumped sum (held between dumps)
//   ovf             overflow flag for the run dumped with dout_valid
module math_acc_dump #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ACC_WIDTH = 24,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] len,
  input  logic                 din_valid,
  input  logic [WIDTH-1:0]     din,
  output logic                 busy,
  output logic                 dout_valid,
  output logic [ACC_WIDTH-1:0] dout,
  output logic                 ovf
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

`ifdef MATH_ACC_DUMP_SAT_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 run_ovf_q, run_ovf_d;
  logic                 busy_q, busy_d;
  logic                 dout_valid_q, dout_valid_d;
  logic [ACC_WIDTH-1:0] dout_q, dout_d;
  logic                 ovf_q, ovf_d;

  logic [ACC_WIDTH-1:0] din_ext;
  logic [ACC_WIDTH-1:0] sum_wrap;
  logic [ACC_WIDTH-1:0] sum_next;
  logic                 add_ovf;
  logic                 run_ovf_nxt;

  // Adder with signed overflow detection: same-sign operands, result sign differs.
  always_comb begin
    din_ext     = ACC_WIDTH'($signed(din));
    sum_wrap    = acc_q + din_ext;
    add_ovf     = (acc_q[ACC_WIDTH-1] == din_ext[ACC_WIDTH-1]) &&
                  (sum_wrap[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    run_ovf_nxt = run_ovf_q | add_ovf;
`ifdef MATH_ACC_DUMP_SAT_EN
    // Once a run has overflowed the accumulator already sits at a clamp value
    // and stays there until the dump.
    if (run_ovf_q) begin
      sum_next = acc_q;
    end else if (add_ovf) begin
      sum_next = acc_q[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
    end else begin
      sum_next = sum_wrap;
    end
`else
    sum_next = sum_wrap;
`endif
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    run_ovf_d    = run_ovf_q;
    dout_valid_d = 1'b0;
    dout_d       = dout_q;
    ovf_d        = ovf_q;

    // start wins over din_valid in both states: sample in that cycle is dropped.
    if (start) begin
      state_d   = S_RUN;
      len_d     = len;
      cnt_d     = '0;
      acc_d     = '0;
      run_ovf_d = 1'b0;
      ovf_d     = 1'b0;
    end else if (state_q == S_RUN && din_valid) begin
      if (cnt_q == len_q) begin
        dout_d       = sum_next;
        ovf_d        = run_ovf_nxt;
        dout_valid_d = 1'b1;
        cnt_d        = '0;
        acc_d        = '0;
        run_ovf_d    = 1'b0;
      end else begin
        acc_d     = sum_next;
        cnt_d     = cnt_q + CNT_WIDTH'(1);
        run_ovf_d = run_ovf_nxt;
      end
    end

    busy_d = (state_d == S_RUN);
  end

  // State registers; ena freezes everything including the dout_valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      run_ovf_q    <= 1'b0;
      busy_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      ovf_q        <= 1'b0;
    end else if (ena) begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      run_ovf_q    <= run_ovf_d;
      busy_q       <= busy_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
      ovf_q        <= ovf_d;
    end
  end

  assign busy       = busy_q;
  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_math_acc_dump.sv
// Directed self-checking bench for math_acc_dump: a default-width instance
// and a 16-bit accumulator instance share the same stimulus.
module tb_math_acc_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        start;
  logic [7:0]  len;
  logic        din_valid;
  logic [15:0] din;

  logic        busy, dout_valid, ovf;
  logic [23:0] dout;
  logic        busy16, dout_valid16, ovf16;
  logic [15:0] dout16;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  math_acc_dump u_dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .len(len),
    .din_valid(din_valid), .din(din),
    .busy(busy), .dout_valid(dout_valid), .dout(dout), .ovf(ovf)
  );

  math_acc_dump #(.WIDTH(16), .ACC_WIDTH(16), .CNT_WIDTH(8)) u_dut16 (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .len(len),
    .din_valid(din_valid), .din(din),
    .busy(busy16), .dout_valid(dout_valid16), .dout(dout16), .ovf(ovf16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one rising edge, settle 1 time unit past it.
  task automatic cyc(input logic s, input logic [7:0] l, input logic v,
                     input logic [15:0] d, input logic e);
    start = s; len = l; din_valid = v; din = d; ena = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; start = 1'b0; len = 8'd0; din_valid = 1'b0; din = 16'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_dv", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;

    // IDLE ignores samples
    cyc(0, 8'd0, 1, 16'd9, 1);
    chk("idle_busy", busy, 0);
    chk("idle_dv", dout_valid, 0);

    // len=3: 100,-20,5,7 -> 92
    cyc(1, 8'd3, 1, 16'd50, 1);
    chk("t1_busy_start", busy, 1);
    chk("t1_dv_start", dout_valid, 0);
    cyc(0, 8'd0, 1, 16'd100, 1);
    chk("t1_dv_s1", dout_valid, 0);
    cyc(0, 8'd0, 1, 16'hFFEC, 1);
    chk("t1_dv_s2", dout_valid, 0);
    cyc(0, 8'd0, 1, 16'd5, 1);
    chk("t1_dv_s3", dout_valid, 0);
    chk("t1_busy_s3", busy, 1);
    cyc(0, 8'd0, 1, 16'd7, 1);
    chk("t1_dv_dump", dout_valid, 1);
    chk("t1_dout", dout, 32'd92);
    chk("t1_ovf", ovf, 0);
    chk("t1_busy_dump", busy, 1);
    cyc(0, 8'd0, 0, 16'd0, 1);
    chk("t1_dv_clear", dout_valid, 0);
    chk("t1_dout_hold", dout, 32'd92);

    // len=1 continuous: 1,2,3,4 -> 3,7
    cyc(1, 8'd1, 0, 16'd0, 1);
    cyc(0, 8'd0, 1, 16'd1, 1);
    chk("t2_dv_s1", dout_valid, 0);
    cyc(0, 8'd0, 1, 16'd2, 1);
    chk("t2_dv_d1", dout_valid, 1);
    chk("t2_dout_d1", dout, 32'd3);
    cyc(0, 8'd0, 1, 16'd3, 1);
    chk("t2_dv_s3", dout_valid, 0);
    cyc(0, 8'd0, 1, 16'd4, 1);
    chk("t2_dv_d2", dout_valid, 1);
    chk("t2_dout_d2", dout, 32'd7);

    // restart: len=7, three samples, start len=0, then -5
    cyc(1, 8'd7, 0, 16'd0, 1);
    chk("t3_dv_start", dout_valid, 0);
    cyc(0, 8'd0, 1, 16'd1, 1);
    cyc(0, 8'd0, 1, 16'd2, 1);
    cyc(0, 8'd0, 1, 16'd3, 1);
    cyc(1, 8'd0, 1, 16'd99, 1);
    chk("t3_dv_restart", dout_valid, 0);
    chk("t3_dout_held", dout, 32'd7);
    cyc(0, 8'd0, 1, 16'hFFFB, 1);
    chk("t3_dv", dout_valid, 1);
    chk("t3_dout", dout, 32'h00FFFFFB);
    chk("t3_dout16", dout16, 32'h0000FFFB);

    // ena gaps: len=1, 10 then 20 held under ena=0 for 4 cycles
    cyc(1, 8'd1, 0, 16'd0, 1);
    cyc(0, 8'd0, 1, 16'd10, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 8'd0, 1, 16'd20, 0);
      chk("t4_dv_frozen", dout_valid, 0);
      chk("t4_dout_frozen", dout, 32'h00FFFFFB);
      chk("t4_busy_frozen", busy, 1);
    end
    cyc(0, 8'd0, 1, 16'd20, 1);
    chk("t4_dv", dout_valid, 1);
    chk("t4_dout", dout, 32'd30);
    cyc(0, 8'd0, 0, 16'd0, 0);
    cyc(0, 8'd0, 0, 16'd0, 0);
    chk("t4_dv_held", dout_valid, 1);
    cyc(0, 8'd0, 0, 16'd0, 1);
    chk("t4_dv_clear", dout_valid, 0);

    // positive overflow on the 16-bit accumulator: 32767 + 1
    cyc(1, 8'd1, 0, 16'd0, 1);
    cyc(0, 8'd0, 1, 16'h7FFF, 1);
    cyc(0, 8'd0, 1, 16'd1, 1);
    chk("t5_dv16", dout_valid16, 1);
    chk("t5_ovf16", ovf16, 1);
`ifdef MATH_ACC_DUMP_SAT_EN
    chk("t5_dout16", dout16, 32'h00007FFF);
`else
    chk("t5_dout16", dout16, 32'h00008000);
`endif
    chk("t5_dout24", dout, 32'h00008000);
    chk("t5_ovf24", ovf, 0);

    // ovf clears on next start
    cyc(1, 8'd2, 0, 16'd0, 1);
    chk("t5_ovf16_clr", ovf16, 0);

    // negative overflow then further add: -32768, -1, 5
    cyc(0, 8'd0, 1, 16'h8000, 1);
    cyc(0, 8'd0, 1, 16'hFFFF, 1);
    cyc(0, 8'd0, 1, 16'd5, 1);
    chk("t6_dv16", dout_valid16, 1);
    chk("t6_ovf16", ovf16, 1);
`ifdef MATH_ACC_DUMP_SAT_EN
    chk("t6_dout16", dout16, 32'h00008000);
`else
    chk("t6_dout16", dout16, 32'h00008004);
`endif
    chk("t6_dout24", dout, 32'h00FF8004);
    chk("t6_ovf24", ovf, 0);

    // async reset mid-run
    cyc(1, 8'd3, 0, 16'd0, 1);
    cyc(0, 8'd0, 1, 16'd1, 1);
    cyc(0, 8'd0, 1, 16'd2, 1);
    #2 rst = 1'b1;
    #1;
    chk("t7_busy", busy, 0);
    chk("t7_dv", dout_valid, 0);
    chk("t7_dout", dout, 0);
    chk("t7_ovf16", ovf16, 0);
    cyc(0, 8'd0, 1, 16'd3, 1);
    rst = 1'b0;
    cyc(0, 8'd0, 1, 16'd4, 1);
    chk("t7_busy_post", busy, 0);
    chk("t7_dv_post", dout_valid, 0);
    chk("t7_dout_post", dout, 0);
    cyc(1, 8'd0, 0, 16'd0, 1);
    chk("t7_busy_start", busy, 1);
    cyc(0, 8'd0, 1, 16'd4, 1);
    chk("t7_dv_len0", dout_valid, 1);
    chk("t7_dout_len0", dout, 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/math_acc_dump.md
MATH_ACC_DUMP -- requirements
Module: math_acc_dump

Interface
REQ-001 SHALL have parameter WIDTH, default 16: input sample bit width (signed).
REQ-002 SHALL have parameter ACC_WIDTH, default 24: accumulator/output bit width (signed); ACC_WIDTH >= WIDTH.
REQ-003 SHALL have parameter CNT_WIDTH, default 8: bit width of length port and internal sample counter.
REQ-004 SHALL have ports:
- clk  input  1  clock; all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- ena  input  1  clock enable, active-high
- start  input  1  begin new integration run (single-cycle pulse)
- len  input  CNT_WIDTH  samples per dump minus one (N = len+1)
- din_valid  input  1  din carries a sample this cycle
- din  input  WIDTH  signed sample (sum output of upstream fabric adder)
- busy  output  1  high while in RUN state
- dout_valid  output  1  one-cycle pulse, dout holds a completed sum
- dout  output  ACC_WIDTH  signed integrated sum
- ovf  output  1  run overflowed ACC_WIDTH; qualified by dout_valid

Function
REQ-005 SHALL implement states IDLE and RUN; from reset the state SHALL be IDLE.
REQ-006 SHALL sample every input and update every register only in cycles with ena=1; with ena=0 all state and outputs SHALL hold, and dout_valid SHALL hold its value.
REQ-007 SHALL, in IDLE with start=1, latch len, clear accumulator, counter and overflow, and enter RUN; din_valid in that same cycle SHALL be ignored.
REQ-008 SHALL, in RUN with din_valid=1, add sign-extended din to the accumulator and increment the counter.
REQ-009 SHALL, on the sample where counter equals latched len, register acc+din into dout, set dout_valid=1 in the next ena cycle, clear accumulator and counter, and remain in RUN (continuous integrate-and-dump).
REQ-010 SHALL produce dout_valid exactly one ena cycle after the final sample of a run (latency 1) and de-assert it on the next ena cycle.
REQ-011 SHALL hold dout between dumps at the last dumped value.
REQ-012 SHALL treat start=1 in RUN as a restart: partial sum discarded, new len latched, no dout_valid for the discarded run, din_valid that cycle ignored.
REQ-013 SHALL return from RUN to IDLE only via reset; len=0 SHALL dump every valid sample (dout = sign-extended din).
REQ-014 SHALL detect signed overflow of any addition within a run and report it via ovf together with that run's dout_valid; ovf SHALL clear at the start of the next run.
REQ-015 SHALL ignore din_valid in IDLE.

Reset
REQ-016 SHALL on rst=1, regardless of clk and ena, force: state IDLE, busy=0, dout_valid=0, dout=0, ovf=0, accumulator=0, counter=0, latched len=0.
REQ-017 SHALL, when rst asserts mid-run, discard the run without emitting dout_valid.
REQ-018 SHALL accept start on the first rising edge after rst de-asserts.

Configuration
REQ-019 SHALL, with macro MATH_ACC_DUMP_SAT_EN defined, clamp the accumulator on overflow to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1) and hold it clamped for the rest of the run (ovf still set).
REQ-020 SHALL, without MATH_ACC_DUMP_SAT_EN, wrap modulo 2^ACC_WIDTH (two's complement) and set ovf only.

Verification
REQ-021 SHALL cover: start with len=3, valid samples 100,-20,5,7 -> one dout_valid pulse one cycle after the 4th sample, dout=92, ovf=0, busy=1 throughout.
REQ-022 SHALL cover: len=1, continuous valid samples 1,2,3,4 -> dout_valid pulses with dout=3 then 7, no gap cycles.
REQ-023 SHALL cover: WIDTH=16, ACC_WIDTH=16, len=1, samples 32767,1 -> ovf=1; dout=32767 with MATH_ACC_DUMP_SAT_EN, dout=-32768 without.
REQ-024 SHALL cover: len=7, 3 samples then start with len=0, then sample -5 -> no dump for partial run, next dout=-5.
REQ-025 SHALL cover: ena=0 for 4 cycles between final sample and dump edge -> dout_valid appears on first ena=1 edge, lasts one ena cycle; state frozen while ena=0.
REQ-026 SHALL cover: rst asserted asynchronously between clock edges mid-run -> all outputs 0 immediately, no dout_valid, busy=0 until next start.
